keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  4x4 matrix keypad scanner and debouncer, directly downstream of the keypad clock divider.
//  Consumes the divider's slow square wave (scan_clk), drives rows active-low one at a time
//  and samples the active-low columns. Emits one debounced 4-bit key code per press, with a
//  single-clk valid pulse, for the operand-entry logic of the FP adder/subtractor.
// PARAMETERS
//  DEBOUNCE_TICKS  3   consecutive identical pressed samples needed to accept a key (>=2)
//  RELEASE_TICKS   3   consecutive all-released samples needed to re-arm scanning (>=1)
//  CNT_W           8   width of the debounce/release counter (must hold max of both)
// PORTS
//  clk        in   1  system clock; every flop is clocked by clk only
//  reset      in   1  asynchronous, active-high reset
//  scan_clk   in   1  divided square wave from the clock divider, synchronous to clk
//  col_n      in   4  keypad columns, active-low (pulled up), asynchronous to clk
//  row_n      out  4  keypad row drive, active-low, exactly one bit low at all times
//  key_code   out  4  {row[1:0],col[1:0]} of the accepted key (row*4+col)
//  key_valid  out  1  one-clk pulse when key_code is updated
//  key_held   out  1  high while an accepted key has not yet been released
// BEHAVIOUR
//  Clocking/reset
//   - reset (async, active-high) forces: row_n=4'b1110 (row 0), key_code=0, key_valid=0,
//     key_held=0, state=SCAN, counter=0, row index=0, sync flops=all ones, scan_q=0.
//   - Asserting reset mid-debounce or mid-hold aborts with no key_valid pulse.
//  Timing and sampling
//   - col_n passes through 2-flop synchroniser -> col_s. scan_q <= scan_clk.
//   - tick = scan_clk & ~scan_q: one clk wide, once per scan_clk rising edge.
//     The design requires scan_clk period >= 8 clk.
//   - All state changes below happen only on tick cycles. Non-tick cycles hold all state.
//   - Pressed sample: any col_s bit low. Selected column is the lowest-index low bit.
//  FSM
//   - SCAN, on tick:
//       pressed   -> latch row idx + selected col, counter=1, go DEBOUNCE (row_n unchanged)
//       otherwise -> row idx = row idx+1 mod 4 (3 wraps to 0), row_n updated same edge
//   - DEBOUNCE, on tick:
//       pressed with same selected col -> counter+1
//         if counter+1 == DEBOUNCE_TICKS -> key_code={row,col}, key_valid=1 next clk,
//           key_held=1, counter=0, go HELD
//       different col, or released -> counter=0, advance row, go SCAN (no output)
//   - HELD (row_n stays on latched row), on tick:
//       all col_s high -> counter+1
//         if counter+1 == RELEASE_TICKS -> key_held=0, counter=0, advance row, go SCAN
//       any low -> counter=0
//     A second key pressed while HELD is ignored. No repeat, no rollover.
//  Outputs
//   - key_valid is high exactly one clk, in the cycle after the accepting tick.
//   - key_code changes only in that same cycle. It holds its value otherwise, including
//     after release.
//   - Press latency: DEBOUNCE_TICKS ticks from first pressed sample, +1 clk, +2 clk sync.
//   - Counter saturates at 2^CNT_W-1 (unreachable with legal parameters).
// TESTING  (bench: DEBOUNCE_TICKS=3, RELEASE_TICKS=2, scan_clk period 20 clk)
//  1 reset, no keys -> row_n cycles 1110,1101,1011,0111,1110 one step per tick.
//     key_valid never rises.
//  2 hold row2/col1 for 10 ticks -> exactly one key_valid pulse, key_code=4'h9,
//     key_held=1 until 2 ticks after release, then scanning resumes at row 3.
//  3 row0/col3 bounce: low 2 ticks, high 1 tick, then low 5 ticks -> no pulse on the
//     first burst. Single pulse with key_code=4'h3 on the 3rd tick of the second burst.
//  4 row1 cols 0 and 2 pressed together -> key_code=4'h4 (lowest col wins).
//     Press of row3/col3 during HELD -> no second pulse.
//  5 assert reset during DEBOUNCE (after 2 matching ticks) -> outputs at reset values
//     immediately, row_n=1110, no key_valid, and the next press needs a full 3-tick debounce.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and release detection.
// Rows are driven active-low one at a time; one debounced key code is emitted per press.
module keypad_scanner #(
  parameter int unsigned DEBOUNCE_TICKS = 3,
  parameter int unsigned RELEASE_TICKS  = 3,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_clk,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned ROW_W = 2;
  localparam int unsigned COL_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d, sel_col;
  logic [3:0]       col_meta, col_s;
  logic             scan_q;
  logic             tick;
  logic             pressed;
  logic [3:0]       row_n_d;
  logic [3:0]       code_d;
  logic             valid_d;
  logic             held_d;

  assign tick    = scan_clk & ~scan_q;
  assign pressed = (col_s != 4'hF);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Lowest-index low column wins when several are pressed together.
  always_comb begin
    sel_col = 2'd3;
    if (!col_s[0])      sel_col = 2'd0;
    else if (!col_s[1]) sel_col = 2'd1;
    else if (!col_s[2]) sel_col = 2'd2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SCAN;
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      col_meta  <= 4'hF;
      col_s     <= 4'hF;
      scan_q    <= 1'b0;
      row_n     <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      col_meta  <= col_n;
      col_s     <= col_meta;
      scan_q    <= scan_clk;
      row_n     <= row_n_d;
      key_code  <= code_d;
      key_valid <= valid_d;
      key_held  <= held_d;
    end
  end

  // Next-state logic: everything advances only on a scan tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    code_d  = key_code;
    valid_d = 1'b0;
    held_d  = key_held;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (pressed) begin
            col_d   = sel_col;
            cnt_d   = CNT_W'(1);
            state_d = DEBOUNCE;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
        DEBOUNCE: begin
          if (pressed && (sel_col == col_q)) begin
            if (cnt_inc == CNT_W'(DEBOUNCE_TICKS)) begin
              code_d  = {row_q, col_q};
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            row_d   = row_q + ROW_W'(1);
            state_d = SCAN;
          end
        end
        HELD: begin
          if (!pressed) begin
            if (cnt_inc == CNT_W'(RELEASE_TICKS)) begin
              held_d  = 1'b0;
              cnt_d   = '0;
              row_d   = row_q + ROW_W'(1);
              state_d = SCAN;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = SCAN;
        end
      endcase
    end
    row_n_d = ~(4'b0001 << row_d);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix model plus a scoreboard of
// expected key codes popped whenever key_valid pulses.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic       scan_clk;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0][3:0] keys;
  logic [3:0]      exp_q[$];
  logic            prev_valid;
  int              n_cmp;
  int              n_err;

  keypad_scanner #(
    .DEBOUNCE_TICKS(3),
    .RELEASE_TICKS (2),
    .CNT_W         (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .scan_clk (scan_clk),
    .col_n    (col_n),
    .row_n    (row_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scan_clk period is 20 clk, changed on the falling clk edge.
  initial begin
    scan_clk = 1'b0;
    forever begin
      repeat (10) @(negedge clk);
      scan_clk = ~scan_clk;
    end
  end

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_n[r]) col_n = col_n & ~keys[r];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard side: every valid pulse must match the oldest expected code.
  initial prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!reset && key_valid) begin
      check("valid_width", 32'(prev_valid), 32'd0);
      if (exp_q.size() == 0) check("spurious_valid", 32'(key_valid), 32'd0);
      else check("key_code", 32'(key_code), 32'(exp_q.pop_front()));
    end
    prev_valid <= key_valid;
  end

  // Returns just after the clk edge on which the DUT sees a scan tick.
  task automatic wait_tick();
    @(posedge scan_clk);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_row0();
    for (int i = 0; i < 8; i++) begin
      wait_tick();
      if (row_n == 4'b1110) return;
    end
    check("row0_seek", 32'(row_n), 32'b1110);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (key_valid) begin
        #1;
        return;
      end
    end
    check("valid_timeout", 32'(key_valid), 32'd1);
  endtask

  logic [3:0] exp_row [5];

  initial begin
    n_cmp = 0;
    n_err = 0;
    keys  = '0;
    reset = 1'b1;
    exp_row[0] = 4'b1101;
    exp_row[1] = 4'b1011;
    exp_row[2] = 4'b0111;
    exp_row[3] = 4'b1110;
    exp_row[4] = 4'b1101;
    repeat (3) @(negedge clk);
    #1;
    check("rst_row_n", 32'(row_n), 32'b1110);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Idle scanning walks the rows once per tick.
    for (int i = 0; i < 5; i++) begin
      wait_tick();
      check("idle_row", 32'(row_n), 32'(exp_row[i]));
    end

    // Row 2 / col 1 held, then released.
    keys[2] = 4'b0010;
    exp_q.push_back(4'h9);
    wait_valid();
    check("held_after_press", 32'(key_held), 32'd1);
    repeat (6) wait_tick();
    check("held_row_n", 32'(row_n), 32'b1011);
    check("held_still", 32'(key_held), 32'd1);
    keys = '0;
    wait_tick();
    check("release_t1_held", 32'(key_held), 32'd1);
    wait_tick();
    check("release_t2_held", 32'(key_held), 32'd0);
    check("resume_row3", 32'(row_n), 32'b0111);
    check("code_kept", 32'(key_code), 32'h9);

    // Row 0 / col 3 bounce: a 2-tick burst must not be accepted.
    wait_row0();
    keys[0] = 4'b1000;
    wait_tick();
    check("bounce_row_hold", 32'(row_n), 32'b1110);
    wait_tick();
    check("bounce_t2_valid", 32'(key_valid), 32'd0);
    keys = '0;
    wait_tick();
    check("bounce_abort_row", 32'(row_n), 32'b1101);
    wait_row0();
    keys[0] = 4'b1000;
    wait_tick();
    check("burst2_t1", 32'(key_valid), 32'd0);
    wait_tick();
    check("burst2_t2", 32'(key_valid), 32'd0);
    exp_q.push_back(4'h3);
    wait_tick();
    check("burst2_t3", 32'(key_valid), 32'd1);
    check("burst2_code", 32'(key_code), 32'h3);
    keys = '0;
    repeat (2) wait_tick();
    check("burst2_released", 32'(key_held), 32'd0);

    // Row 1 cols 0 and 2 together; a row 3 press while held is ignored.
    keys[1] = 4'b0101;
    exp_q.push_back(4'h4);
    wait_valid();
    check("multi_code", 32'(key_code), 32'h4);
    keys[3] = 4'b1000;
    repeat (6) wait_tick();
    check("ignore_held", 32'(key_held), 32'd1);
    check("ignore_code", 32'(key_code), 32'h4);
    keys = '0;
    repeat (3) wait_tick();
    check("multi_released", 32'(key_held), 32'd0);

    // Reset during debounce aborts; the next press needs a full debounce.
    wait_row0();
    keys[0] = 4'b0001;
    repeat (2) wait_tick();
    check("pre_rst_valid", 32'(key_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_row_n", 32'(row_n), 32'b1110);
    check("mid_rst_code", 32'(key_code), 32'd0);
    check("mid_rst_held", 32'(key_held), 32'd0);
    check("mid_rst_valid", 32'(key_valid), 32'd0);
    repeat (12) @(negedge clk);
    reset = 1'b0;
    wait_tick();
    check("post_rst_t1", 32'(key_valid), 32'd0);
    check("post_rst_row", 32'(row_n), 32'b1110);
    wait_tick();
    check("post_rst_t2", 32'(key_valid), 32'd0);
    exp_q.push_back(4'h0);
    wait_tick();
    check("post_rst_t3", 32'(key_valid), 32'd1);
    check("post_rst_held", 32'(key_held), 32'd1);
    keys = '0;
    repeat (3) wait_tick();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
